// File: rtl/gray_frame_stats.sv
// Per-frame geometry and luma statistics on the gray video stream, with a 1-cycle passthrough.
// The mean luma is produced by a restoring divider that runs during the following frame.
module gray_frame_stats #(
   parameter int unsigned COUNT_W   = 12,
   parameter int unsigned SUM_W     = 32,
   parameter bit          VSYNC_POL = 1'b1
) (
   input  logic               clk_pix,
   input  logic               rst_n,
   input  logic [23:0]        vid_data,
   input  logic               pHSync,
   input  logic               pVSync,
   input  logic               pVDE,
   output logic [23:0]        OUT_vid_data,
   output logic               OUT_pHSync,
   output logic               OUT_pVSync,
   output logic               OUT_pVDE,
   output logic [COUNT_W-1:0] frame_width,
   output logic [COUNT_W-1:0] frame_height,
   output logic [7:0]         luma_min,
   output logic [7:0]         luma_max,
   output logic [7:0]         luma_avg,
   output logic               stats_valid,
   output logic               stats_locked,
   output logic               width_err,
   output logic               overrun
);
   localparam int unsigned PW     = 2*COUNT_W;
   localparam int unsigned STEP_W = $clog2(SUM_W+2);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;
   state_t state_q, state_d;

   logic [23:0]        vid_q;
   logic               hs_q, vs_q, de_q, vs_act_q;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [PW-1:0]      cnt_q, cnt_d;
   logic [COUNT_W-1:0] lcnt_q, lcnt_d, hgt_q, hgt_d, wid_q, wid_d;
   logic [7:0]         min_q, min_d, max_q, max_d;
   logic               err_q, err_d;

   logic [7:0]         luma;
   logic               frame_edge, line_end, start_div;
   logic [COUNT_W-1:0] hgt_eff, wid_eff;
   logic               err_eff;

   assign luma       = vid_data[7:0];
   assign frame_edge = (pVSync == VSYNC_POL) && !vs_act_q;
   assign line_end   = de_q && !pVDE && (lcnt_q != '0);

   // A line ending in the edge cycle still belongs to the frame being closed.
   always_comb begin
      hgt_eff = hgt_q;
      wid_eff = wid_q;
      err_eff = err_q;
      if (line_end) begin
         hgt_eff = hgt_q + COUNT_W'(1);
         if (hgt_q == '0)        wid_eff = lcnt_q;
         else if (lcnt_q != wid_q) err_eff = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      lcnt_d    = lcnt_q;
      hgt_d     = hgt_q;
      wid_d     = wid_q;
      min_d     = min_q;
      max_d     = max_q;
      err_d     = err_q;
      start_div = 1'b0;
      if (frame_edge) begin
         state_d   = S_ACCUM;
         start_div = (state_q == S_ACCUM);
         sum_d     = pVDE ? SUM_W'(luma) : '0;
         cnt_d     = PW'(pVDE);
         lcnt_d    = COUNT_W'(pVDE);
         hgt_d     = '0;
         wid_d     = '0;
         err_d     = 1'b0;
         min_d     = pVDE ? luma : 8'hFF;
         max_d     = pVDE ? luma : 8'h00;
      end else if (state_q == S_ACCUM) begin
         hgt_d = hgt_eff;
         wid_d = wid_eff;
         err_d = err_eff;
         if (line_end) lcnt_d = '0;
         if (pVDE) begin
            sum_d  = sum_q + SUM_W'(luma);
            cnt_d  = cnt_q + PW'(1);
            lcnt_d = lcnt_q + COUNT_W'(1);
            if (luma < min_q) min_d = luma;
            if (luma > max_q) max_d = luma;
         end
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         vid_q    <= '0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         de_q     <= 1'b0;
         vs_act_q <= 1'b0;
         state_q  <= S_IDLE;
         sum_q    <= '0;
         cnt_q    <= '0;
         lcnt_q   <= '0;
         hgt_q    <= '0;
         wid_q    <= '0;
         min_q    <= '0;
         max_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         vid_q    <= vid_data;
         hs_q     <= pHSync;
         vs_q     <= pVSync;
         de_q     <= pVDE;
         vs_act_q <= (pVSync == VSYNC_POL);
         state_q  <= state_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         lcnt_q   <= lcnt_d;
         hgt_q    <= hgt_d;
         wid_q    <= wid_d;
         min_q    <= min_d;
         max_q    <= max_d;
         err_q    <= err_d;
      end
   end

   logic               busy_q;
   logic [STEP_W-1:0]  step_q;
   logic [SUM_W-1:0]   num_q;
   logic [PW:0]        rem_q, rem_sh, rem_nx;
   logic [PW-1:0]      den_q;
   logic [COUNT_W-1:0] s_wid_q, s_hgt_q, pub_w, pub_h;
   logic [7:0]         s_min_q, s_max_q, quot_sat;
   logic               s_err_q, q_bit;
   logic [COUNT_W-1:0] fw_q, fh_q;
   logic [7:0]         lmin_q, lmax_q, lavg_q;
   logic               valid_q, locked_q, werr_q, ovr_q, pub_q;

   // num_q shifts dividend bits out of the top while quotient bits enter at the bottom.
   always_comb begin
      rem_sh   = {rem_q[PW-1:0], num_q[SUM_W-1]};
      q_bit    = (rem_sh >= {1'b0, den_q});
      rem_nx   = q_bit ? (rem_sh - {1'b0, den_q}) : rem_sh;
      quot_sat = (num_q[SUM_W-1:8] != '0) ? 8'hFF : num_q[7:0];
      pub_w    = (den_q == '0) ? '0 : s_wid_q;
      pub_h    = (den_q == '0) ? '0 : s_hgt_q;
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         step_q   <= '0;
         num_q    <= '0;
         rem_q    <= '0;
         den_q    <= '0;
         s_wid_q  <= '0;
         s_hgt_q  <= '0;
         s_min_q  <= '0;
         s_max_q  <= '0;
         s_err_q  <= 1'b0;
         fw_q     <= '0;
         fh_q     <= '0;
         lmin_q   <= '0;
         lmax_q   <= '0;
         lavg_q   <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         werr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         pub_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (start_div) begin
            if (busy_q) ovr_q <= 1'b1;
            busy_q  <= 1'b1;
            step_q  <= '0;
            num_q   <= sum_q;
            rem_q   <= '0;
            den_q   <= cnt_q;
            s_wid_q <= wid_eff;
            s_hgt_q <= hgt_eff;
            s_min_q <= min_q;
            s_max_q <= max_q;
            s_err_q <= err_eff;
         end else if (busy_q) begin
            step_q <= step_q + STEP_W'(1);
            if (step_q == STEP_W'(SUM_W + 1)) begin
               busy_q   <= 1'b0;
               valid_q  <= 1'b1;
               pub_q    <= 1'b1;
               fw_q     <= pub_w;
               fh_q     <= pub_h;
               lmin_q   <= (den_q == '0) ? 8'h00 : s_min_q;
               lmax_q   <= (den_q == '0) ? 8'h00 : s_max_q;
               lavg_q   <= (den_q == '0) ? 8'h00 : quot_sat;
               werr_q   <= s_err_q;
               locked_q <= pub_q && (pub_w == fw_q) && (pub_h == fh_q) && !s_err_q;
            end else if ((step_q < STEP_W'(SUM_W)) && (den_q != '0)) begin
               num_q <= {num_q[SUM_W-2:0], q_bit};
               rem_q <= rem_nx;
            end
         end
      end
   end

   assign OUT_vid_data = vid_q;
   assign OUT_pHSync   = hs_q;
   assign OUT_pVSync   = vs_q;
   assign OUT_pVDE     = de_q;
   assign frame_width  = fw_q;
   assign frame_height = fh_q;
   assign luma_min     = lmin_q;
   assign luma_max     = lmax_q;
   assign luma_avg     = lavg_q;
   assign stats_valid  = valid_q;
   assign stats_locked = locked_q;
   assign width_err    = werr_q;
   assign overrun      = ovr_q;
endmodule

// File: tb/tb_gray_frame_stats.sv
// Bench for gray_frame_stats: passthrough table, hand-checked frame sequences, and random
// frames checked against a frame-level model that derives stats from recorded pixels and lines.
module tb_gray_frame_stats;
   localparam int unsigned COUNT_W = 12;
   localparam int unsigned SUM_W   = 32;
   localparam int          LAT     = SUM_W + 2;

   logic               clk_pix = 1'b0;
   logic               rst_n   = 1'b1;
   logic [23:0]        vid_data = '0;
   logic               pHSync = 1'b0, pVSync = 1'b0, pVDE = 1'b0;
   logic [23:0]        OUT_vid_data;
   logic               OUT_pHSync, OUT_pVSync, OUT_pVDE;
   logic [COUNT_W-1:0] frame_width, frame_height;
   logic [7:0]         luma_min, luma_max, luma_avg;
   logic               stats_valid, stats_locked, width_err, overrun;

   gray_frame_stats #(.COUNT_W(COUNT_W), .SUM_W(SUM_W), .VSYNC_POL(1'b1)) dut (
      .clk_pix(clk_pix), .rst_n(rst_n), .vid_data(vid_data), .pHSync(pHSync),
      .pVSync(pVSync), .pVDE(pVDE), .OUT_vid_data(OUT_vid_data), .OUT_pHSync(OUT_pHSync),
      .OUT_pVSync(OUT_pVSync), .OUT_pVDE(OUT_pVDE), .frame_width(frame_width),
      .frame_height(frame_height), .luma_min(luma_min), .luma_max(luma_max),
      .luma_avg(luma_avg), .stats_valid(stats_valid), .stats_locked(stats_locked),
      .width_err(width_err), .overrun(overrun)
   );

   always #5 clk_pix = ~clk_pix;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   always @(posedge clk_pix) cyc <= cyc + 1;

   typedef struct { int cyc; int w; int h; int mn; int mx; int avg; bit err; } exp_t;
   typedef struct { logic [23:0] vid; bit hs; bit de; bit vs;
                    logic [23:0] e_vid; bit e_hs; bit e_de; bit e_vs; } pt_t;

   exp_t expq[$];
   int   pix[$];
   int   lines[$];
   int   cur_len = 0;
   bit   prev_vs = 0, prev_de = 0, in_accum = 0, ovr = 0, has_pub = 0;
   int   pw = 0, ph = 0;
   int   line_len[8];
   pt_t  pt[5];
   exp_t mon_r;
   bit   mon_lk;

   task automatic chk(input string nm, input int act, input int want);
      vectors++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // A frame closes at each edge seen while already accumulating; its result is due LAT cycles later.
   task automatic model_edge(input int e);
      exp_t r;
      int   sum;
      if (in_accum) begin
         if (expq.size() > 0 && expq[expq.size()-1].cyc >= e) begin
            expq.delete(expq.size()-1);
            ovr = 1;
         end
         r.cyc = e + LAT; r.h = lines.size(); r.w = 0; r.err = 0;
         r.mn = 255; r.mx = 0; r.avg = 0; sum = 0;
         if (r.h > 0) r.w = lines[0];
         foreach (lines[i]) if (lines[i] != r.w) r.err = 1;
         foreach (pix[i]) begin
            sum += pix[i];
            if (pix[i] < r.mn) r.mn = pix[i];
            if (pix[i] > r.mx) r.mx = pix[i];
         end
         if (pix.size() == 0) begin
            r.mn = 0; r.mx = 0; r.w = 0; r.h = 0;
         end else begin
            r.avg = sum / pix.size();
         end
         expq.push_back(r);
      end
      in_accum = 1;
      pix.delete();
      lines.delete();
      cur_len = 0;
   endtask

   task automatic apply(input bit vs, input bit hs, input bit de, input logic [23:0] v);
      pVSync = vs; pHSync = hs; pVDE = de; vid_data = v;
   endtask

   task automatic step();
      bit vs, de;
      int l;
      vs = pVSync; de = pVDE; l = int'(vid_data[7:0]);
      @(posedge clk_pix); #1;
      if (prev_de && !de) begin
         if (cur_len > 0) lines.push_back(cur_len);
         cur_len = 0;
      end
      if (vs && !prev_vs) model_edge(cyc);
      if (de) begin
         pix.push_back(l);
         cur_len++;
      end
      prev_vs = vs; prev_de = de;
   endtask

   task automatic cyc1(input bit vs, input bit hs, input bit de, input logic [23:0] v);
      apply(vs, hs, de, v);
      step();
   endtask

   task automatic set_lens(input int a, input int b, input int c, input int d);
      line_len[0] = a; line_len[1] = b; line_len[2] = c; line_len[3] = d;
   endtask

   // mode 0: constant cval, 1: ramp 0,1,2.. across the frame, 2: random luma
   task automatic send_frame(input int nl, input int mode, input int cval);
      int t0, k;
      logic [7:0] l;
      t0 = cyc + 1; k = 0;
      repeat (3) cyc1(1, 0, 0, '0);
      repeat (4) cyc1(0, 0, 0, '0);
      for (int li = 0; li < nl; li++) begin
         cyc1(0, 1, 0, '0);
         cyc1(0, 0, 0, '0);
         for (int p = 0; p < line_len[li]; p++) begin
            case (mode)
               0:       l = 8'(cval);
               1:       l = 8'(k);
               default: l = 8'($urandom_range(0, 255));
            endcase
            k++;
            cyc1(0, 0, 1, {3{l}});
         end
         cyc1(0, 0, 0, '0);
      end
      while (cyc < t0 + 45) cyc1(0, 0, 0, '0);
   endtask

   task automatic short_frame(input int cval);
      repeat (3) cyc1(1, 0, 0, '0);
      repeat (5) cyc1(0, 0, 1, {3{8'(cval)}});
      repeat (2) cyc1(0, 0, 0, '0);
   endtask

   task automatic hand(input string tag, input int w, input int h, input int mn, input int mx,
                       input int avg, input int err, input int lk, input int ov);
      chk({tag, " width"},  int'(frame_width),  w);
      chk({tag, " height"}, int'(frame_height), h);
      chk({tag, " min"},    int'(luma_min),     mn);
      chk({tag, " max"},    int'(luma_max),     mx);
      chk({tag, " avg"},    int'(luma_avg),     avg);
      chk({tag, " werr"},   int'(width_err),    err);
      chk({tag, " locked"}, int'(stats_locked), lk);
      chk({tag, " overrun"}, int'(overrun),     ov);
   endtask

   task automatic do_reset();
      apply(0, 0, 0, '0);
      rst_n = 1'b0;
      #1;
      chk("rst OUT_vid_data", int'(OUT_vid_data), 0);
      chk("rst OUT_sync", int'({OUT_pHSync, OUT_pVSync, OUT_pVDE}), 0);
      chk("rst stats_valid", int'(stats_valid), 0);
      hand("rst", 0, 0, 0, 0, 0, 0, 0, 0);
      expq.delete(); pix.delete(); lines.delete();
      in_accum = 0; ovr = 0; has_pub = 0; pw = 0; ph = 0;
      prev_vs = 0; prev_de = 0; cur_len = 0;
      repeat (3) @(posedge clk_pix);
      #1 rst_n = 1'b1;
   endtask

   always @(negedge clk_pix) begin
      if (rst_n) begin
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            mon_r = expq.pop_front();
            mon_lk = has_pub && (mon_r.w == pw) && (mon_r.h == ph) && !mon_r.err;
            chk("stats_valid pulse", int'(stats_valid), 1);
            chk("frame_width", int'(frame_width), mon_r.w);
            chk("frame_height", int'(frame_height), mon_r.h);
            chk("luma_min", int'(luma_min), mon_r.mn);
            chk("luma_max", int'(luma_max), mon_r.mx);
            chk("luma_avg", int'(luma_avg), mon_r.avg);
            chk("width_err", int'(width_err), int'(mon_r.err));
            chk("stats_locked", int'(stats_locked), int'(mon_lk));
            chk("overrun", int'(overrun), int'(ovr));
            has_pub = 1; pw = mon_r.w; ph = mon_r.h;
         end else if (stats_valid) begin
            chk("stats_valid unexpected", int'(stats_valid), 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pt[0] = '{24'h101010, 0, 1, 0, 24'h101010, 0, 1, 0};
      pt[1] = '{24'h202020, 0, 1, 0, 24'h202020, 0, 1, 0};
      pt[2] = '{24'h101010, 1, 0, 0, 24'h101010, 1, 0, 0};
      pt[3] = '{24'h202020, 1, 1, 0, 24'h202020, 1, 1, 0};
      pt[4] = '{24'h5A5A5A, 0, 0, 1, 24'h5A5A5A, 0, 0, 1};

      #2;
      do_reset();

      for (int i = 0; i < 5; i++) begin
         logic [23:0] prev_vid;
         prev_vid = OUT_vid_data;
         apply(pt[i].vs, pt[i].hs, pt[i].de, pt[i].vid);
         #1;
         chk("pt no early update", int'(OUT_vid_data), int'(prev_vid));
         step();
         chk("pt OUT_vid_data", int'(OUT_vid_data), int'(pt[i].e_vid));
         chk("pt OUT_pHSync", int'(OUT_pHSync), int'(pt[i].e_hs));
         chk("pt OUT_pVDE", int'(OUT_pVDE), int'(pt[i].e_de));
         chk("pt OUT_pVSync", int'(OUT_pVSync), int'(pt[i].e_vs));
      end
      cyc1(0, 0, 0, '0);

      set_lens(4, 4, 4, 0);
      send_frame(3, 0, 100);
      send_frame(2, 1, 0);
      hand("const", 4, 3, 100, 100, 100, 0, 0, 0);
      send_frame(2, 1, 0);
      hand("ramp1", 4, 2, 0, 7, 3, 0, 0, 0);
      set_lens(4, 5, 4, 0);
      send_frame(3, 0, 50);
      hand("ramp2", 4, 2, 0, 7, 3, 0, 1, 0);
      send_frame(0, 0, 0);
      hand("badline", 4, 3, 50, 50, 50, 1, 0, 0);
      set_lens(4, 4, 4, 0);
      send_frame(3, 0, 20);
      hand("zero", 0, 0, 0, 0, 0, 0, 0, 0);
      short_frame(77);
      send_frame(3, 0, 20);
      hand("short", 5, 1, 77, 77, 77, 0, 0, 1);

      for (int f = 0; f < 8; f++) begin
         int nl, w;
         nl = $urandom_range(1, 4);
         w  = $urandom_range(1, 6);
         for (int li = 0; li < 4; li++)
            line_len[li] = (li > 0 && $urandom_range(0, 3) == 0) ? w + 1 : w;
         send_frame(nl, 2, 0);
      end
      send_frame(0, 0, 0);

      set_lens(3, 3, 0, 0);
      send_frame(2, 0, 9);
      repeat (3) cyc1(0, 0, 1, 24'h090909);
      do_reset();

      send_frame(2, 0, 9);
      send_frame(2, 0, 11);
      repeat (3) cyc1(1, 0, 0, '0);
      repeat (4) cyc1(0, 0, 0, '0);
      do_reset();
      repeat (50) cyc1(0, 0, 0, '0);
      send_frame(2, 0, 13);
      send_frame(2, 0, 15);
      hand("after reset", 3, 2, 13, 13, 13, 0, 0, 0);
      send_frame(0, 0, 0);
      hand("relock", 3, 2, 15, 15, 15, 0, 1, 0);

      repeat (40) cyc1(0, 0, 0, '0);
      chk("pending pulses", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/gray_frame_stats.md
Name: gray_frame_stats

Overview:
Sits directly downstream of the grayscale converter and consumes its 24-bit gray video and sync bundle. Passes the bundle through with one register stage. Per frame, it measures active width and height, luma min, luma max and truncated mean luma. A multi-cycle sequential divider computes the mean during the following frame, and results are published with a one-cycle valid pulse for software and auto-exposure logic.

Parameters:
COUNT_W, 12, width of pixel/line counters (max 4095 px/line, 4095 lines)
SUM_W, 32, luma accumulator width; must be >= 2*COUNT_W+8
VSYNC_POL, 1, active level of pVSync (1 = active-high)

Ports:
clk_pix  input  1  pixel clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
vid_data  input  24  gray video; luma taken from [7:0] (all three bytes equal)
pHSync  input  1  horizontal sync
pVSync  input  1  vertical sync
pVDE  input  1  active-video enable
OUT_vid_data  output  24  vid_data delayed 1 cycle
OUT_pHSync  output  1  pHSync delayed 1 cycle
OUT_pVSync  output  1  pVSync delayed 1 cycle
OUT_pVDE  output  1  pVDE delayed 1 cycle
frame_width  output  COUNT_W  active pixels on first active line of last frame
frame_height  output  COUNT_W  active lines (lines with >=1 DE pixel) of last frame
luma_min  output  8  minimum luma of last frame
luma_max  output  8  maximum luma of last frame
luma_avg  output  8  floor(sum / pixel_count) of last frame
stats_valid  output  1  one-cycle pulse when all stats outputs update
stats_locked  output  1  last two published frames had equal width/height and no width error
width_err  output  1  sticky per frame: a line's DE length differed from the first line
overrun  output  1  sticky: a result was dropped because the divider was busy; cleared by reset only

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; accumulators cleared.
- Passthrough: all four OUT_* signals register their inputs, 1-cycle latency, no modification.
- Frame edge: pVSync transitions to its active level (VSYNC_POL), detected against the previous-cycle registered sample. Edge cycle = the cycle the new level is sampled.
- FSM states:
  - IDLE: ignore video until the first frame edge, then go to ACCUM. The first partial frame is never reported.
  - ACCUM: on each cycle with pVDE=1, add luma to sum, increment pixel count and line pixel count, and update min/max. Min initialises to 255 and max to 0 at frame start.
  - Line end: pVDE 1->0. If line pixel count >0, increment height. The first such line stores the width; any later line with a different count sets width_err for the frame.
  - ACCUM on frame edge: snapshot sum, count, width, height, min, max and width_err. Clear accumulators in the same cycle, stay in ACCUM for the new frame, and start the divider.
  - A pixel with pVDE=1 in the edge cycle belongs to the new frame.
- Divider: restoring, one quotient bit per cycle over SUM_W bits, independent of ACCUM.
  - stats_valid pulses exactly SUM_W+2 cycles after the edge cycle. All stats outputs update in that same cycle and then hold.
  - Quotient saturates to 255. This can only occur on illegal input.
  - Zero-pixel frame (count=0): divider skipped. Pulse at the same latency with avg=0, min=0, max=0, width=0, height=0.
- Divider busy at a new frame edge: the in-flight result is discarded, overrun is set, and the divider restarts on the new snapshot.
- stats_locked: set at stats_valid when width/height equal the previous published values and width_err=0. Otherwise cleared at stats_valid.
- width_err output updates only at stats_valid.
- pVSync held active for many cycles counts as one edge. pHSync is not used for counting; passthrough only.

Test Plan:
- Reset then pattern check: apply 5 pixels, then check OUT_* equals inputs delayed exactly 1 cycle, values 0x101010/0x202020.
- Constant frame: 4x3 active, luma 100. At the next frame edge + 34 cycles: stats_valid=1, width=4, height=3, avg=100, min=max=100, width_err=0.
- Ramp frame: 4x2, luma 0..7 -> avg=3 (28/8=3.5 floors), min=0, max=7. Two identical frames -> stats_locked=1 on the second pulse.
- Bad line: 4x3 frame with line 2 of 5 pixels -> width=4, height=3, width_err=1, stats_locked=0.
- Short frame: second VSync edge 10 cycles after the first, with VDE pixels -> first result dropped, overrun=1, a single stats_valid 34 cycles after the second edge. Zero-DE frame -> all stats 0, pulse still occurs.
- Reset mid-frame (rst_n low for 3 cycles during ACCUM and again during divide) -> outputs 0 immediately. No stats_valid until a full frame completes after re-entering from IDLE.
